// File: rtl/serial_frame_deserializer.sv
// Start/data/parity/stop serial receiver with a one-word valid/ready output buffer.
// Parity and framing errors and overruns are flagged per frame.
module serial_frame_deserializer #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int ODD       = 0
) (
  input  logic             clock,
  input  logic             Rst,
  input  logic             D,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             par_bit;
  logic             stop_good, stop_bad, par_calc, load;

  always_ff @(posedge clock or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!D) nxt = DATA;
      DATA:    if (cnt == LAST) nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  nxt = STOP;
      STOP:    nxt = D ? IDLE : BREAK;
      BREAK:   if (D) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign stop_good = (state == STOP) && D;
  assign stop_bad  = (state == STOP) && !D;
  assign par_calc  = (PARITY_EN != 0) && ((^sreg ^ par_bit) != (ODD != 0));
  // A finished word may only be taken if the buffer is empty or draining this edge.
  assign load      = stop_good && (!valid || ready);

  always_ff @(posedge clock or posedge Rst) begin
    if (Rst) begin
      cnt        <= '0;
      sreg       <= '0;
      par_bit    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_good && valid && !ready;
      case (state)
        IDLE:    cnt <= '0;
        DATA: begin
          // LSB first: shifting right leaves the first bit in bit 0 after WIDTH shifts.
          sreg <= {D, sreg[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
        end
        PARITY:  par_bit <= D;
        default: ;
      endcase
      if (load) begin
        data       <= sreg;
        parity_err <= par_calc;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer (WIDTH=8, even parity).
module tb_serial_frame_deserializer;

  logic       clock = 1'b0;
  logic       Rst, D, ready;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, overrun;
  int         checks = 0;
  int         failures = 0;

  serial_frame_deserializer #(.WIDTH(8), .PARITY_EN(1), .ODD(0)) dut (
    .clock(clock), .Rst(Rst), .D(D), .data(data), .valid(valid), .ready(ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Drive one bit, let it be sampled, then settle just past the edge.
  task automatic tick(input logic b);
    D = b;
    @(posedge clock);
    #1;
  endtask

  // Start, 8 data bits LSB first, parity bit; stop bit is left to the caller.
  task automatic send_body(input logic [7:0] w, input logic p);
    tick(1'b0);
    for (int i = 0; i < 8; i++) tick(w[i]);
    tick(p);
  endtask

  task automatic test_reset;
    Rst = 1'b1; D = 1'b1; ready = 1'b0;
    #3;
    checks++;
    if ({valid, parity_err, frame_err, overrun, data} !== 12'h000) begin
      failures++; $display("FAIL reset_async got=%h exp=000", {valid, parity_err, frame_err, overrun, data});
    end
    @(posedge clock); @(posedge clock); #1;
    Rst = 1'b0;
    tick(1'b1); tick(1'b1);
    checks++;
    if ({valid, parity_err, frame_err, overrun, data} !== 12'h000) begin
      failures++; $display("FAIL reset_idle got=%h exp=000", {valid, parity_err, frame_err, overrun, data});
    end
  endtask

  task automatic test_a5_good;
    ready = 1'b1;
    send_body(8'hA5, 1'b0);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL a5_early_valid got=%b exp=0", valid); end
    tick(1'b1);
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL a5_valid got=%b exp=1", valid); end
    checks++;
    if (data !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", data); end
    checks++;
    if (parity_err !== 1'b0) begin failures++; $display("FAIL a5_perr got=%b exp=0", parity_err); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL a5_ferr got=%b exp=0", frame_err); end
    tick(1'b1);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL a5_accept got=%b exp=0", valid); end
    checks++;
    if (data !== 8'hA5) begin failures++; $display("FAIL a5_data_hold got=%h exp=a5", data); end
  endtask

  task automatic test_parity_err;
    ready = 1'b1;
    send_body(8'hA5, 1'b1);
    tick(1'b1);
    checks++;
    if ({valid, parity_err, data} !== {1'b1, 1'b1, 8'hA5}) begin
      failures++; $display("FAIL perr_word got=%h exp=3a5", {valid, parity_err, data});
    end
    tick(1'b1);
    checks++;
    if ({valid, parity_err} !== 2'b01) begin
      failures++; $display("FAIL perr_hold got=%b exp=01", {valid, parity_err});
    end
  endtask

  task automatic test_frame_err;
    ready = 1'b1;
    send_body(8'h55, 1'b0);
    tick(1'b0);
    checks++;
    if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL ferr_no_load got=%b exp=0", valid); end
    tick(1'b0);
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_one_cycle got=%b exp=0", frame_err); end
    for (int i = 0; i < 4; i++) tick(1'b0);
    checks++;
    if ({valid, frame_err} !== 2'b00) begin
      failures++; $display("FAIL break_quiet got=%b exp=00", {valid, frame_err});
    end
    tick(1'b1);
    send_body(8'h3C, 1'b0);
    tick(1'b1);
    checks++;
    if ({valid, parity_err, data} !== {1'b1, 1'b0, 8'h3C}) begin
      failures++; $display("FAIL break_recover got=%h exp=23c", {valid, parity_err, data});
    end
    tick(1'b1);
  endtask

  task automatic test_overrun;
    ready = 1'b0;
    send_body(8'h3C, 1'b0);
    tick(1'b1);
    checks++;
    if ({valid, overrun, data} !== {1'b1, 1'b0, 8'h3C}) begin
      failures++; $display("FAIL ovr_first got=%h exp=23c", {valid, overrun, data});
    end
    send_body(8'hC3, 1'b0);
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    tick(1'b1);
    checks++;
    if ({valid, overrun, data} !== {1'b1, 1'b1, 8'h3C}) begin
      failures++; $display("FAIL ovr_pulse got=%h exp=33c", {valid, overrun, data});
    end
    tick(1'b1);
    checks++;
    if ({valid, overrun} !== 2'b10) begin
      failures++; $display("FAIL ovr_one_cycle got=%b exp=10", {valid, overrun});
    end
    ready = 1'b1;
    tick(1'b1);
    checks++;
    if ({valid, data} !== {1'b0, 8'h3C}) begin
      failures++; $display("FAIL ovr_drain got=%h exp=03c", {valid, data});
    end
  endtask

  task automatic test_back_to_back;
    ready = 1'b0;
    send_body(8'h11, 1'b0);
    tick(1'b1);
    checks++;
    if ({valid, data} !== {1'b1, 8'h11}) begin
      failures++; $display("FAIL b2b_first got=%h exp=111", {valid, data});
    end
    send_body(8'h7E, 1'b1);
    ready = 1'b1;
    tick(1'b1);
    checks++;
    if ({valid, parity_err, overrun, data} !== {1'b1, 1'b1, 1'b0, 8'h7E}) begin
      failures++; $display("FAIL b2b_swap got=%h exp=67e", {valid, parity_err, overrun, data});
    end
    tick(1'b1);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", valid); end
  endtask

  task automatic test_rst_midframe;
    ready = 1'b1;
    tick(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({valid, parity_err, frame_err, overrun, data} !== 12'h000) begin
      failures++; $display("FAIL rst_mid got=%h exp=000", {valid, parity_err, frame_err, overrun, data});
    end
    #1 Rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL rst_no_stale got=%b exp=0", valid); end
    send_body(8'h01, 1'b1);
    tick(1'b1);
    checks++;
    if ({valid, parity_err, data} !== {1'b1, 1'b0, 8'h01}) begin
      failures++; $display("FAIL rst_next_word got=%h exp=201", {valid, parity_err, data});
    end
  endtask

  initial begin
    test_reset;
    test_a5_good;
    test_parity_err;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_rst_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_deserializer.md
# serial_frame_deserializer

Receives a one-bit-per-clock serial stream framed as start bit, WIDTH data bits (LSB first), optional parity bit and stop bit, and presents each completed word on a parallel output with a valid/ready handshake. The block sits directly downstream of the D flip-flop stage: its serial input is that flop's registered Q output, sampled on the same clock. Parity and framing errors and overruns are flagged per frame.

## Interface

- WIDTH, 8, number of data bits per frame (2..32)
- PARITY_EN, 1, 1 = parity bit present after the data bits; 0 = no parity bit
- ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)

- clock  input  1  single clock; all sampling on posedge
- Rst  input  1  reset, asynchronous, active-high
- D  input  1  serial line; idles high; one bit per clock
- data  output  WIDTH  received word, held until accepted
- valid  output  1  data holds an unaccepted word
- ready  input  1  consumer accepts data when valid && ready at a posedge
- parity_err  output  1  parity mismatch on the word currently in data; qualified by valid
- frame_err  output  1  one-cycle pulse: stop bit sampled low, frame discarded
- overrun  output  1  one-cycle pulse: completed frame dropped because data was still occupied

## Operation

- States: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: D = 0 at a posedge -> DATA, bit counter = 0. D = 1 -> stay.
- DATA: each posedge shifts D into a WIDTH-bit shift register (first bit lands in bit 0); after WIDTH bits -> PARITY if PARITY_EN, else STOP.
- PARITY: sample D as the parity bit -> STOP.
- Parity check: error when (XOR of data bits) XOR (parity bit) != ODD.
- STOP, D = 1: frame good -> IDLE. Load rules below.
- STOP, D = 0: frame discarded, frame_err pulses for one cycle -> BREAK. No load, valid unchanged.
- BREAK: wait for D = 1 -> IDLE. A start bit is not recognised until the line has returned high.
- Load on good stop:
  - valid = 0, or valid = 1 with ready = 1 in the same cycle: data <= shift register, parity_err <= check result, valid <= 1.
  - valid = 1 with ready = 0: new word dropped; data, parity_err and valid unchanged; overrun pulses for one cycle.
- Acceptance: valid && ready at a posedge with no simultaneous load -> valid <= 0. data and parity_err keep their last values.
- Words with a parity error are still delivered; parity_err is set alongside them.
- Reset (asynchronous, mid-frame included): state IDLE, counter 0, shift register 0, data 0, valid 0, parity_err 0, frame_err 0, overrun 0. A partial frame is lost.

## Timing

- Start bit sampled at edge k. Data bits are sampled at edges k+1..k+WIDTH, parity at k+WIDTH+1, and stop at k+WIDTH+1+PARITY_EN.
- valid, data and parity_err update at the stop-bit edge and are visible immediately after it. For WIDTH = 8 with parity, that is edge k+10.
- frame_err and overrun are registered pulses, high for exactly the cycle after the stop-bit edge.
- Back-to-back frames: a start bit at the edge right after the stop edge is accepted (frame period WIDTH+2+PARITY_EN clocks).
- ready affects only the handshake and never stalls reception. All outputs are registered.

## Test plan

- 0xA5, even parity, ready = 1: D = 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1 -> data = 0xA5, valid = 1 at edge k+10, parity_err = 0; valid drops one cycle later.
- Same frame with parity bit 1 -> data = 0xA5, valid = 1, parity_err = 1.
- Stop bit sampled 0 -> valid stays 0 and frame_err pulses one cycle. D is held 0 for 5 more clocks, then raised and followed by a 0x3C frame -> no false start while low; 0x3C is received correctly.
- ready = 0; frames 0x3C then 0xC3 back-to-back -> data stays 0x3C, overrun pulses one cycle at the second stop edge; raising ready then drops valid.
- ready held 1 while a new frame completes on the same edge the old word is accepted -> new word loaded, valid stays 1, no overrun.
- Rst pulsed after 4 data bits of 0xFF -> all outputs 0 immediately, without waiting for a clock. A subsequent 0x01 frame gives data = 0x01, parity_err = 0.
